// File: rtl/sa_input_skewer.sv
// sa_input_skewer: assembles host activation/weight words into per-row byte
// vectors and feeds the systolic array with a diagonal skew (row r lags row 0
// by r array steps), then flushes the skew with zero vectors.

// One skewed lane: stage 0 captures the incoming byte, deeper stages shift.
// A lane of depth r presents the byte injected r steps earlier.
module sa_skew_lane #(
  parameter int DEPTH = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       step,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [DEPTH:0][7:0] sr;

  // shift only on array steps; cleared at the start of every pass
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (step) begin
      sr[0] <= din;
      for (int i = 1; i <= DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH];
endmodule

module sa_input_skewer #(
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32,
  parameter int KW       = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic [OUTWIDTH-1:0] a_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [OUTWIDTH-1:0] w_data,
  input  logic                w_valid,
  output logic                w_ready,
  output logic                fire,
  output logic [ROWS*8-1:0]   a_out,
  output logic [ROWS*8-1:0]   w_out,
  output logic                busy,
  output logic                done
);
  localparam int BEATS = ROWS * 8 / OUTWIDTH;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int DW    = (ROWS > 2) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                         state, state_nxt;
  logic [KW-1:0]                  k_reg, vec_cnt;
  logic [DW-1:0]                  drain_cnt;
  logic [CW-1:0]                  a_cnt, w_cnt;
  logic [BEATS-1:0][OUTWIDTH-1:0] a_buf, w_buf;
  logic [ROWS*8-1:0]              a_vec, w_vec;
  logic issue, last_vec, last_drain, step, clr;
  logic a_acc, w_acc, last_fire, last_fire_nxt, done_nxt;

  // vector issue needs both buffers full; the last vector closes the stream
  assign issue      = (state == RUN) && (a_cnt == CW'(BEATS)) && (w_cnt == CW'(BEATS));
  assign last_vec   = (vec_cnt == k_reg - KW'(1));
  assign last_drain = (state == DRAIN) && (drain_cnt == DW'(ROWS - 2));
  assign step       = issue || (state == DRAIN);
  assign clr        = (state == IDLE) && start && (k_len != '0);

  // a full buffer can still take a beat in the issue cycle, unless it was the last vector
  assign a_ready = (state == RUN) && ((a_cnt < CW'(BEATS)) || (issue && !last_vec));
  assign w_ready = (state == RUN) && ((w_cnt < CW'(BEATS)) || (issue && !last_vec));
  assign a_acc   = a_valid && a_ready;
  assign w_acc   = w_valid && w_ready;
  assign busy    = (state != IDLE);

  // beat b byte j already sits at row b*(OUTWIDTH/8)+j in the flattened buffer
  assign a_vec = issue ? a_buf : '0;
  assign w_vec = issue ? w_buf : '0;

  assign last_fire_nxt = last_drain || ((ROWS == 1) && issue && last_vec);
  assign done_nxt      = last_fire || ((state == IDLE) && start && (k_len == '0));

  // pass sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && k_len != '0) state_nxt = RUN;
      RUN:     if (issue && last_vec) state_nxt = (ROWS == 1) ? IDLE : DRAIN;
      DRAIN:   if (last_drain) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, pass counters and the fire/done strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      k_reg     <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      fire      <= 1'b0;
      last_fire <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      fire      <= step;
      last_fire <= last_fire_nxt;
      done      <= done_nxt;
      if (clr) begin
        k_reg     <= k_len;
        vec_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        if (issue) vec_cnt <= vec_cnt + KW'(1);
        if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
      end
    end
  end

  // beat counters: an issue empties the buffer, a same-cycle beat refills slot 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_cnt <= '0;
      w_cnt <= '0;
    end else if (clr) begin
      a_cnt <= '0;
      w_cnt <= '0;
    end else begin
      if (issue)      a_cnt <= a_acc ? CW'(1) : '0;
      else if (a_acc) a_cnt <= a_cnt + CW'(1);
      if (issue)      w_cnt <= w_acc ? CW'(1) : '0;
      else if (w_acc) w_cnt <= w_cnt + CW'(1);
    end
  end

  // assembly buffers, written one beat slot at a time in row order
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_buf <= '0;
      w_buf <= '0;
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        if (a_acc && (issue ? (b == 0) : (a_cnt == CW'(b)))) a_buf[b] <= a_data;
        if (w_acc && (issue ? (b == 0) : (w_cnt == CW'(b)))) w_buf[b] <= w_data;
      end
    end
  end

  // row r gets an r-deep skew for both operand streams
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    sa_skew_lane #(.DEPTH(r)) u_a (
      .clk(clk), .rstn(rstn), .clr(clr), .step(step),
      .din(a_vec[8*r +: 8]), .dout(a_out[8*r +: 8])
    );
    sa_skew_lane #(.DEPTH(r)) u_w (
      .clk(clk), .rstn(rstn), .clr(clr), .step(step),
      .din(w_vec[8*r +: 8]), .dout(w_out[8*r +: 8])
    );
  end
endmodule

// File: tb/tb_sa_input_skewer.sv
// Directed bench for sa_input_skewer: scenario table plus hand-written
// zero-length, mid-pass reset and restart sequences.
module tb_sa_input_skewer;
  localparam int ROWS     = 8;
  localparam int OUTWIDTH = 32;
  localparam int KW       = 16;
  localparam int BEATS    = ROWS * 8 / OUTWIDTH;
  localparam int BPB      = OUTWIDTH / 8;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic [KW-1:0]       k_len = '0;
  logic [OUTWIDTH-1:0] a_data = '0, w_data = '0;
  logic                a_valid = 1'b0, w_valid = 1'b0;
  logic                a_ready, w_ready, fire, busy, done;
  logic [ROWS*8-1:0]   a_out, w_out;

  sa_input_skewer #(.ROWS(ROWS), .OUTWIDTH(OUTWIDTH), .KW(KW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .fire(fire), .a_out(a_out), .w_out(w_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int k; int amode; int wdel; int restart_at; int exp_fires; int done_off;
  } scen_t;
  typedef struct {
    logic [ROWS*8-1:0] a;
    logic [ROWS*8-1:0] w;
  } fire_t;

  fire_t tbl[ROWS];

  int n_chk = 0, n_fail = 0;
  bit mon_en = 0;
  int k_cur, a_idx, w_idx, pass_t0, start_cyc;
  logic [ROWS*8-1:0] fa[$], fw[$];
  int fc[$];
  int done_cnt, done_cyc, hold_viol, inc_viol, ahead_viol, stall_a;
  bit seen, any_busy, any_ready;
  logic [ROWS*8-1:0] la, lw;

  function automatic logic [7:0] abyte(input int v, input int r);
    return 8'(16 * v + r + 1);
  endfunction

  function automatic logic [7:0] wbyte(input int v, input int r);
    return 8'(16 * v + r + 'h11);
  endfunction

  function automatic logic [OUTWIDTH-1:0] beat_word(input int idx, input bit is_w);
    logic [OUTWIDTH-1:0] wd;
    int v, b;
    wd = '0;
    v = idx / BEATS;
    b = idx % BEATS;
    for (int j = 0; j < BPB; j++)
      wd[8*j +: 8] = is_w ? wbyte(v, b*BPB + j) : abyte(v, b*BPB + j);
    return wd;
  endfunction

  // fire n, row r carries vector n-r when that vector exists in the pass
  function automatic logic [ROWS*8-1:0] exp_vec(input int n, input int k, input bit is_w);
    logic [ROWS*8-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      if (n - r >= 0 && n - r < k) v[8*r +: 8] = is_w ? wbyte(n - r, r) : abyte(n - r, r);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // observe fires, done, holds and handshake behaviour away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (fire) begin
        if (int'(fa.size()) < k_cur &&
            (a_idx < (int'(fa.size()) + 1) * BEATS || w_idx < (int'(fa.size()) + 1) * BEATS))
          inc_viol++;
        fa.push_back(a_out);
        fw.push_back(w_out);
        fc.push_back(cyc);
        la = a_out;
        lw = w_out;
        seen = 1;
      end else if (seen && (a_out !== la || w_out !== lw)) begin
        hold_viol++;
      end
      if (a_idx > (int'(fa.size()) + 1) * BEATS || w_idx > (int'(fa.size()) + 1) * BEATS)
        ahead_viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) any_busy = 1;
      if (a_ready || w_ready) any_ready = 1;
      if (a_valid && !a_ready && busy) stall_a++;
    end
  end

  // amode 1: a_valid only on even cycles; wdel 1: weights of vector v wait
  // 5 cycles after its activations are complete
  task automatic run_pass(input int k, input int amode, input int wdel,
                          input int restart_at, input int abort_at);
    int a_cmpl[64];
    bit acc_a, acc_w, aborted;
    int wv;
    k_cur = k; a_idx = 0; w_idx = 0;
    fa.delete(); fw.delete(); fc.delete();
    done_cnt = 0; done_cyc = -1; seen = 0;
    hold_viol = 0; inc_viol = 0; ahead_viol = 0; stall_a = 0;
    any_busy = 0; any_ready = 0; aborted = 0;
    foreach (a_cmpl[i]) a_cmpl[i] = 0;
    mon_en = 1;
    start = 1; k_len = KW'(k); start_cyc = cyc;
    @(posedge clk); #1;
    start = 0; pass_t0 = cyc;
    while (done_cnt == 0 && cyc - pass_t0 < 400) begin
      a_valid = (a_idx < k * BEATS) && (amode == 0 || cyc % 2 == 0);
      a_data  = beat_word(a_idx, 0);
      wv      = w_idx / BEATS;
      w_valid = (w_idx < k * BEATS) &&
                (wdel == 0 || (a_idx >= (wv + 1) * BEATS && cyc >= a_cmpl[wv] + 5));
      w_data  = beat_word(w_idx, 1);
      start   = (restart_at >= 0 && cyc - pass_t0 == restart_at);
      k_len   = start ? KW'(5) : KW'(k);
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_w = w_valid && w_ready;
      @(posedge clk); #1;
      if (acc_a) begin
        a_idx++;
        if (a_idx % BEATS == 0) a_cmpl[a_idx / BEATS - 1] = cyc;
      end
      if (acc_w) w_idx++;
      if (abort_at > 0 && int'(fa.size()) >= abort_at) begin
        aborted = 1;
        break;
      end
    end
    a_valid = 0; w_valid = 0; start = 0;
    if (!aborted) begin
      repeat (3) @(posedge clk);
      #1;
    end
    mon_en = 0;
  endtask

  task automatic chk_tbl();
    for (int n = 0; n < ROWS; n++) begin
      chk("k1_table_a_out", (n < int'(fa.size())) ? fa[n] : '1, tbl[n].a);
      chk("k1_table_w_out", (n < int'(fw.size())) ? fw[n] : '1, tbl[n].w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 time units");
    $fatal(1);
  end

  initial begin
    scen_t sc[4];
    int dn;
    int k;

    // k_len=1, vector a = 1..8, w = 0x11..0x18: fire n shows only row n
    for (int n = 0; n < ROWS; n++) begin
      tbl[n].a = '0;
      tbl[n].w = '0;
      tbl[n].a[8*n +: 8] = 8'(n + 1);
      tbl[n].w[8*n +: 8] = 8'(8'h11 + n);
    end
    //          k  amode wdel restart fires done_off
    sc[0] = '{1, 0,    0,   -1,     8,    11};
    sc[1] = '{3, 1,    0,   -1,     10,   -1};
    sc[2] = '{3, 0,    0,    3,     10,   15};
    sc[3] = '{2, 0,    1,   -1,     9,    -1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {fire, busy, done, a_ready, w_ready}, 5'b0);
    chk("reset_a_out", a_out, '0);
    chk("reset_w_out", w_out, '0);
    @(negedge clk);
    rstn = 1;

    // zero-length pass
    run_pass(0, 0, 0, -1, -1);
    chk("k0_done_next_cycle", done_cyc - start_cyc, 1);
    chk("k0_done_count", done_cnt, 1);
    chk("k0_no_fire", fa.size(), 0);
    chk("k0_no_busy", any_busy, 0);
    chk("k0_no_ready", any_ready, 0);

    for (int s = 0; s < 4; s++) begin
      k = sc[s].k;
      run_pass(k, sc[s].amode, sc[s].wdel, sc[s].restart_at, -1);
      chk("fire_count", fa.size(), sc[s].exp_fires);
      chk("done_count", done_cnt, 1);
      chk("done_after_last_fire", (fc.size() > 0) ? done_cyc - fc[fc.size()-1] : -1, 1);
      for (int n = 0; n < int'(fa.size()); n++) begin
        chk("a_out_skew", fa[n], exp_vec(n, k, 0));
        chk("w_out_skew", fw[n], exp_vec(n, k, 1));
      end
      chk("drain_contiguous",
          (int'(fc.size()) == sc[s].exp_fires) ? fc[k+ROWS-2] - fc[k-1] : -1, ROWS - 1);
      chk("hold_in_bubble", hold_viol, 0);
      chk("fire_before_complete", inc_viol, 0);
      chk("buffer_overrun", ahead_viol, 0);
      if (sc[s].done_off >= 0) chk("done_timing", done_cyc - pass_t0, sc[s].done_off);
      if (sc[s].wdel != 0) chk("a_stalls_waiting_w", stall_a > 0, 1);
      if (s == 0) chk_tbl();
    end

    // reset after two fires of a k_len=4 pass
    run_pass(4, 0, 0, -1, 2);
    chk("abort_fires_seen", fa.size(), 2);
    chk("abort_busy_before", busy, 1);
    rstn = 0;
    #1;
    chk("abort_ctrl_zero", {fire, busy, done, a_ready, w_ready}, 5'b0);
    chk("abort_a_out_zero", a_out, '0);
    chk("abort_w_out_zero", w_out, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);

    // a fresh k_len=1 pass after the abort behaves like the first one
    @(posedge clk); #1;
    run_pass(1, 0, 0, -1, -1);
    chk("post_abort_fire_count", fa.size(), 8);
    chk("post_abort_done_timing", done_cyc - pass_t0, 11);
    chk_tbl();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
